// File: rtl/input_event_regs.sv
// Bus-mapped input peripheral: samples debounced switches/buttons, detects edges,
// auto-repeats held buttons, keeps sticky W1C event flags and drives a maskable level irq.
module input_event_regs #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] switch_buf,
  input  logic [3:0]  btn_y_buf,
  input  logic [3:0]  bus_addr,
  input  logic        bus_ren,
  input  logic        bus_wen,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [3:0]  btn_press_o,
  output logic        irq
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] REG_SW   = 2'd0;
  localparam logic [1:0] REG_BTN  = 2'd1;
  localparam logic [1:0] REG_EVT  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } rpt_state_e;

  logic [3:0]  btn_q, btn_prev;
  logic [15:0] sw_q, sw_prev;
  logic [8:0]  evt;
  logic [8:0]  ie;
  logic        repeat_en;

  logic [3:0]  press;
  logic [3:0]  release_ev;
  logic        swchg;
  logic [3:0]  press_pulse;
  logic [8:0]  evt_set;
  logic [8:0]  evt_clr;
  logic        ctrl_wr;
  logic [31:0] rd_mux;

  assign press      = btn_q & ~btn_prev;
  assign release_ev = ~btn_q & btn_prev;
  assign swchg      = |(sw_q ^ sw_prev);

  // Per-button auto-repeat engine; buttons never interact.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse;

    // NOTE: asynchronous reset clears every flop, so state and counter restart from IDLE/0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments only.
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse   = 1'b0;
      if (!btn_q[i]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_d = '0;
            if (press[i]) begin
              state_d = ST_HOLD;
              pulse   = 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              // Without REPEAT_EN the counter parks here, ready to fire once re-enabled.
              if (repeat_en) begin
                state_d = ST_REPEAT;
                cnt_d   = '0;
                pulse   = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!repeat_en) begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_LAST;
            end else if (cnt_q == REPEAT_LAST) begin
              cnt_d = '0;
              pulse = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign press_pulse[i] = pulse;
  end

  assign btn_press_o = press_pulse;
  assign evt_set     = {swchg, release_ev, press_pulse};
  assign evt_clr     = (bus_wen && bus_addr[3:2] == REG_EVT) ? bus_wdata[8:0] : 9'd0;
  assign ctrl_wr     = bus_wen && bus_addr[3:2] == REG_CTRL;

  always_comb begin
    rd_mux = '0;
    case (bus_addr[3:2])
      REG_SW:   rd_mux = {16'd0, sw_q};
      REG_BTN:  rd_mux = {28'd0, btn_q};
      REG_EVT:  rd_mux = {23'd0, evt};
      REG_CTRL: rd_mux = {15'd0, repeat_en, 7'd0, ie};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= '0;
      btn_prev  <= '0;
      sw_q      <= '0;
      sw_prev   <= '0;
      evt       <= '0;
      ie        <= '0;
      repeat_en <= 1'b0;
      irq       <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      btn_q    <= btn_y_buf;
      btn_prev <= btn_q;
      sw_q     <= switch_buf;
      sw_prev  <= sw_q;
      // A new event in the same cycle as its clear keeps the flag set.
      evt      <= (evt & ~evt_clr) | evt_set;
      if (ctrl_wr) begin
        ie        <= bus_wdata[8:0];
        repeat_en <= bus_wdata[16];
      end
      irq       <= |(evt & ie);
      bus_ack   <= bus_ren | bus_wen;
      // A combined read+write strobe acts as a write and returns zero data.
      bus_rdata <= (bus_ren && !bus_wen) ? rd_mux : 32'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:17], bus_wdata[15:9]};

endmodule

// File: tb/tb_input_event_regs.sv
// Self-checking bench for input_event_regs: directed reset/bus/repeat/W1C sequences,
// a vector table, and randomized traffic against an age-based reference model.
module tb_input_event_regs;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] switch_buf = '0;
  logic [3:0]  btn_y_buf = '0;
  logic [3:0]  bus_addr = '0;
  logic        bus_ren = 1'b0;
  logic        bus_wen = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [3:0]  btn_press_o;
  logic        irq;

  int checks = 0;
  int failures = 0;

  input_event_regs #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .switch_buf (switch_buf),
    .btn_y_buf  (btn_y_buf),
    .bus_addr   (bus_addr),
    .bus_ren    (bus_ren),
    .bus_wen    (bus_wen),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .btn_press_o(btn_press_o),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus_ren = 1'b0; bus_wen = 1'b0; bus_addr = '0; bus_wdata = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1; bus_ren = 1'b0;
    @(negedge clk);
    idle_bus();
    check("wr_ack", bus_ack, 1);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; bus_ren = 1'b1; bus_wen = 1'b0;
    @(negedge clk);
    idle_bus();
    check("rd_ack", bus_ack, 1);
    d = bus_rdata;
  endtask

  // Reference model: pulses follow from how long each button has been held.
  logic [3:0]  m_btn_q, m_btn_prev;
  logic [15:0] m_sw_q, m_sw_prev;
  logic [8:0]  m_evt, m_ie;
  logic        m_rep, m_irq, m_ack;
  logic [31:0] m_rdata;
  int          m_age [4];

  task automatic model_reset();
    m_btn_q = '0; m_btn_prev = '0; m_sw_q = '0; m_sw_prev = '0;
    m_evt = '0; m_ie = '0; m_rep = 1'b0; m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0;
    for (int i = 0; i < 4; i++) m_age[i] = -1;
  endtask

  function automatic logic [3:0] model_pulses();
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_btn_q[i] && m_age[i] >= 0) begin
        if (m_age[i] == 0) p[i] = 1'b1;
        else if (m_rep && m_age[i] >= HOLD && (m_age[i] - HOLD) % REP == 0) p[i] = 1'b1;
      end
    end
    return p;
  endfunction

  task automatic model_step(input logic [3:0] b, input logic [15:0] s, input logic ren,
                            input logic wen, input logic [3:0] a, input logic [31:0] wd);
    logic [3:0]  p, rel;
    logic        swc;
    logic [8:0]  clr;
    logic [31:0] rv;
    p   = model_pulses();
    rel = ~m_btn_q & m_btn_prev;
    swc = (m_sw_q != m_sw_prev);
    case (a[3:2])
      2'd0: rv = {16'd0, m_sw_q};
      2'd1: rv = {28'd0, m_btn_q};
      2'd2: rv = {23'd0, m_evt};
      default: rv = {15'd0, m_rep, 7'd0, m_ie};
    endcase
    clr     = (wen && a[3:2] == 2'd2) ? wd[8:0] : 9'd0;
    m_rdata = (ren && !wen) ? rv : 32'd0;
    m_ack   = ren || wen;
    m_irq   = |(m_evt & m_ie);
    m_evt   = (m_evt & ~clr) | {swc, rel, p};
    if (wen && a[3:2] == 2'd3) begin
      m_ie  = wd[8:0];
      m_rep = wd[16];
    end
    for (int i = 0; i < 4; i++) begin
      if (!b[i]) m_age[i] = -1;
      else if (!m_btn_q[i]) m_age[i] = 0;
      else m_age[i] = m_age[i] + 1;
    end
    m_btn_prev = m_btn_q; m_btn_q = b;
    m_sw_prev  = m_sw_q;  m_sw_q  = s;
  endtask

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] sw;
    logic        ren;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_press;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] d;
    logic [31:0] seen, exp_mask;
    int          npulse;
    logic [3:0]  b;
    logic [15:0] s;
    logic        r, w;
    logic [3:0]  a;
    logic [31:0] wd;

    //             btn   sw       ren   wen   addr  wdata           press ack   rdata           irq
    vecs[0]  = '{4'h1, 16'h00, 1'b0, 1'b0, 4'h0, 32'h0,          4'h1, 1'b0, 32'h0,          1'b0};
    vecs[1]  = '{4'h1, 16'h00, 1'b0, 1'b0, 4'h0, 32'h0,          4'h0, 1'b0, 32'h0,          1'b0};
    vecs[2]  = '{4'h1, 16'h00, 1'b1, 1'b0, 4'h8, 32'h0,          4'h0, 1'b1, 32'h001,        1'b0};
    vecs[3]  = '{4'h0, 16'h00, 1'b0, 1'b0, 4'h0, 32'h0,          4'h0, 1'b0, 32'h0,          1'b0};
    vecs[4]  = '{4'h0, 16'h00, 1'b1, 1'b0, 4'h8, 32'h0,          4'h0, 1'b1, 32'h001,        1'b0};
    vecs[5]  = '{4'h0, 16'h00, 1'b1, 1'b0, 4'h8, 32'h0,          4'h0, 1'b1, 32'h011,        1'b0};
    vecs[6]  = '{4'h0, 16'h00, 1'b0, 1'b1, 4'h8, 32'h011,        4'h0, 1'b1, 32'h0,          1'b0};
    vecs[7]  = '{4'h0, 16'h00, 1'b1, 1'b0, 4'hB, 32'h0,          4'h0, 1'b1, 32'h000,        1'b0};
    vecs[8]  = '{4'h0, 16'h20, 1'b0, 1'b0, 4'h0, 32'h0,          4'h0, 1'b0, 32'h0,          1'b0};
    vecs[9]  = '{4'h0, 16'h20, 1'b1, 1'b0, 4'h0, 32'h0,          4'h0, 1'b1, 32'h20,         1'b0};
    vecs[10] = '{4'h0, 16'h20, 1'b1, 1'b0, 4'hA, 32'h0,          4'h0, 1'b1, 32'h100,        1'b0};
    vecs[11] = '{4'h0, 16'h20, 1'b1, 1'b1, 4'hC, 32'h0001_0100,  4'h0, 1'b1, 32'h0,          1'b0};
    vecs[12] = '{4'h0, 16'h20, 1'b1, 1'b0, 4'hC, 32'h0,          4'h0, 1'b1, 32'h0001_0100,  1'b1};
    vecs[13] = '{4'h0, 16'h20, 1'b0, 1'b1, 4'h8, 32'h100,        4'h0, 1'b1, 32'h0,          1'b1};
    vecs[14] = '{4'h0, 16'h20, 1'b0, 1'b0, 4'h0, 32'h0,          4'h0, 1'b0, 32'h0,          1'b0};
    vecs[15] = '{4'h0, 16'h20, 1'b0, 1'b1, 4'h4, 32'hFFFF_FFFF,  4'h0, 1'b1, 32'h0,          1'b0};
    vecs[16] = '{4'h0, 16'h20, 1'b1, 1'b0, 4'hC, 32'h0,          4'h0, 1'b1, 32'h0001_0100,  1'b0};
    vecs[17] = '{4'h0, 16'h20, 1'b1, 1'b0, 4'h0, 32'h0,          4'h0, 1'b1, 32'h20,         1'b0};

    // Reset state, then a reset asserted while btn1 is held in auto-repeat.
    repeat (3) @(negedge clk);
    check("rst_rdata", bus_rdata, 0);
    check("rst_ack", bus_ack, 0);
    check("rst_press", btn_press_o, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_write(4'hC, 32'h0001_01FF);
    btn_y_buf = 4'b0010;
    repeat (5) @(negedge clk);
    check("pre_rst_irq", irq, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rdata", bus_rdata, 0);
    check("midrst_ack", bus_ack, 0);
    check("midrst_press", btn_press_o, 0);
    check("midrst_irq", irq, 0);
    btn_y_buf = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_press", btn_press_o, 0);
      check("postrst_irq", irq, 0);
    end
    bus_read(4'hC, d);
    check("postrst_ctrl", d, 0);
    bus_read(4'h8, d);
    check("postrst_evt", d, 0);

    // Vector table: press/release flags, W1C, switch change, combined strobe, RO writes.
    for (int i = 0; i < 18; i++) begin
      btn_y_buf = vecs[i].btn; switch_buf = vecs[i].sw;
      bus_ren = vecs[i].ren; bus_wen = vecs[i].wen;
      bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_press", i), btn_press_o, vecs[i].exp_press);
      check($sformatf("vec%0d_ack", i), bus_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
    end
    idle_bus();
    bus_write(4'hC, 32'h0);
    bus_write(4'h8, 32'h1FF);

    // irq timing against flag set and mask clear.
    bus_write(4'hC, 32'h1);
    btn_y_buf = 4'b0001;
    @(negedge clk);
    check("irq_press", btn_press_o, 4'b0001);
    check("irq_before_flag", irq, 0);
    @(negedge clk);
    check("irq_flag_cycle", irq, 0);
    @(negedge clk);
    check("irq_set", irq, 1);
    bus_write(4'hC, 32'h0);
    check("irq_mask_edge", irq, 1);
    @(negedge clk);
    check("irq_masked", irq, 0);
    btn_y_buf = 4'b0000;
    repeat (3) @(negedge clk);
    bus_write(4'h8, 32'h1FF);

    // Auto-repeat pattern with REPEAT_EN, then a single pulse without it.
    exp_mask = (32'd1 << 0) | (32'd1 << HOLD) | (32'd1 << (HOLD + REP)) | (32'd1 << (HOLD + 2 * REP));
    bus_write(4'hC, 32'h0001_0000);
    btn_y_buf = 4'b0100;
    seen = '0; npulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (btn_press_o[2]) begin seen[k] = 1'b1; npulse++; end
    end
    check("rep_positions", seen, exp_mask);
    check("rep_count", npulse, 4);
    btn_y_buf = 4'b0000;
    repeat (3) @(negedge clk);
    bus_write(4'hC, 32'h0);
    btn_y_buf = 4'b0100;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (btn_press_o[2]) npulse++;
    end
    check("norep_count", npulse, 1);
    btn_y_buf = 4'b0000;
    repeat (3) @(negedge clk);
    bus_write(4'h8, 32'h1FF);

    // W1C of EVT[3] on the same edge a new btn3 press sets it.
    btn_y_buf = 4'b1000;
    @(negedge clk);
    btn_y_buf = 4'b0000;
    repeat (3) @(negedge clk);
    btn_y_buf = 4'b1000;
    @(negedge clk);
    check("race_press", btn_press_o, 4'b1000);
    bus_addr = 4'h8; bus_wdata = 32'h008; bus_wen = 1'b1;
    @(negedge clk);
    idle_bus();
    bus_read(4'h8, d);
    check("race_evt", d, 32'h088);
    btn_y_buf = 4'b0000;
    repeat (3) @(negedge clk);

    // Randomized traffic against the reference model, from a fresh reset.
    rst_n = 1'b0;
    switch_buf = '0;
    idle_bus();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    b = '0; s = '0;
    for (int c = 0; c < 1600; c++) begin
      check("rnd_press", btn_press_o, model_pulses());
      check("rnd_ack", bus_ack, m_ack);
      check("rnd_rdata", bus_rdata, m_rdata);
      check("rnd_irq", irq, m_irq);
      if (failures > 40) break;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 15) == 0) s[$urandom_range(0, 15)] = ~s[$urandom_range(0, 15)];
      r  = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom);
      wd = $urandom;
      if (a[3:2] == 2'd3) wd[16] = (c >= 800);
      if (c >= 790 && c < 800) b = '0;
      if (c == 799) begin
        r = 1'b0; w = 1'b1; a = 4'hC; wd = {15'd0, 1'b1, 7'd0, 9'($urandom)};
      end
      btn_y_buf = b; switch_buf = s;
      bus_ren = r; bus_wen = w; bus_addr = a; bus_wdata = wd;
      model_step(b, s, r, w, a, wd);
      @(negedge clk);
    end
    idle_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
